// File: rtl/intc_8bit.sv
`timescale 1ns/1ps
// intc_8bit: fixed-priority, edge-triggered interrupt controller with MASK/PENDING/STATUS/EOI port.
// Optional macro INTC_NESTED_EN lets a higher-priority source preempt the one in service.
module intc_8bit #(
    parameter int         NUM_SRC       = 4,
    parameter logic [7:0] VECTOR_BASE   = 8'hF0,
    parameter int         VECTOR_STRIDE = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_SRC-1:0] irq_in,
    input  logic               int_ack,
    output logic               interrupt,
    output logic [7:0]         vector,
    input  logic               cfg_we,
    input  logic [1:0]         cfg_addr,
    input  logic [7:0]         cfg_wdata,
    output logic [7:0]         cfg_rdata
);

    // IDLE: nothing raised | ACK_WAIT: interrupt held until ack | SERVICE: handler running, waits EOI
    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] ACK_WAIT = 2'd1;
    localparam logic [1:0] SERVICE  = 2'd2;

    logic [NUM_SRC-1:0] sync1_q, sync2_q, prev_q;
    logic [NUM_SRC-1:0] pending_q, pending_d;
    logic [NUM_SRC-1:0] insvc_q, insvc_d;
    logic [7:0]         mask_q, mask_d;
    logic [1:0]         state_q, state_d;
    logic [2:0]         cur_id_q, cur_id_d;
    logic               interrupt_q;

    logic [NUM_SRC-1:0] edge_det, eligible, pend_clr, cur_oh;
    logic               win_any, eoi;
    logic [2:0]         win_id;
    logic [7:0]         vec_calc;
`ifdef INTC_NESTED_EN
    logic               ins_any, rem_any;
    logic [2:0]         ins_id, rem_id;
`endif

    // Returns {found, index} of the lowest set bit.
    function automatic logic [3:0] find_low(input logic [NUM_SRC-1:0] v);
        logic [3:0] r;
        r = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (v[i]) r = {1'b1, 3'(i)};
        end
        return r;
    endfunction

    always_comb begin
        edge_det          = sync2_q & ~prev_q;
        eligible          = pending_q & ~mask_q[NUM_SRC-1:0];
        {win_any, win_id} = find_low(eligible);
        cur_oh            = NUM_SRC'(1) << cur_id_q;
        eoi               = cfg_we && (cfg_addr == 2'd3);
`ifdef INTC_NESTED_EN
        {ins_any, ins_id} = find_low(insvc_q);
        {rem_any, rem_id} = find_low(insvc_q & (insvc_q - NUM_SRC'(1)));
`endif
    end

    always_comb begin
        state_d  = state_q;
        cur_id_d = cur_id_q;
        insvc_d  = insvc_q;
        mask_d   = mask_q;
        pend_clr = '0;
        if (cfg_we && cfg_addr == 2'd0) mask_d = cfg_wdata;
        if (cfg_we && cfg_addr == 2'd1) pend_clr = cfg_wdata[NUM_SRC-1:0];
        case (state_q)
            IDLE: begin
                if (win_any) begin
                    state_d  = ACK_WAIT;
                    cur_id_d = win_id;
                end
            end
            ACK_WAIT: begin
                if (int_ack) begin
                    pend_clr = pend_clr | cur_oh;
                    insvc_d  = insvc_q | cur_oh;
                    state_d  = SERVICE;
                end
            end
            SERVICE: begin
`ifdef INTC_NESTED_EN
                if (eoi) begin
                    insvc_d = insvc_q & (insvc_q - NUM_SRC'(1));
                    if (rem_any) cur_id_d = rem_id;
                    else         state_d  = IDLE;
                end else if (win_any && (!ins_any || win_id < ins_id)) begin
                    state_d  = ACK_WAIT;
                    cur_id_d = win_id;
                end
`else
                if (eoi) begin
                    insvc_d = insvc_q & ~cur_oh;
                    state_d = IDLE;
                end
`endif
            end
            default: state_d = IDLE;
        endcase
        // A fresh edge beats any clear landing in the same cycle.
        pending_d = (pending_q & ~pend_clr) | edge_det;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q     <= '0;
            sync2_q     <= '0;
            prev_q      <= '0;
            pending_q   <= '0;
            insvc_q     <= '0;
            mask_q      <= 8'hFF;
            state_q     <= IDLE;
            cur_id_q    <= 3'd0;
            interrupt_q <= 1'b0;
        end else begin
            sync1_q     <= irq_in;
            sync2_q     <= sync1_q;
            prev_q      <= sync2_q;
            pending_q   <= pending_d;
            insvc_q     <= insvc_d;
            mask_q      <= mask_d;
            state_q     <= state_d;
            cur_id_q    <= cur_id_d;
            interrupt_q <= (state_d == ACK_WAIT);
        end
    end

    assign vec_calc  = 8'(32'(VECTOR_BASE) + 32'(cur_id_q) * VECTOR_STRIDE);
    assign interrupt = interrupt_q;
    assign vector    = (state_q == ACK_WAIT || state_q == SERVICE) ? vec_calc : 8'h00;

    always_comb begin
        cfg_rdata = 8'h00;
        case (cfg_addr)
            2'd0:    cfg_rdata = mask_q;
            2'd1:    cfg_rdata = 8'(pending_q);
            2'd2:    cfg_rdata = {state_q, 1'b0, |insvc_q, 1'b0, cur_id_q};
            default: cfg_rdata = 8'h00;
        endcase
    end

endmodule

// File: tb/tb_intc_8bit.sv
`timescale 1ns/1ps
// tb_intc_8bit: directed tests of intc_8bit latency, priority, masking, commit, async reset and nesting.
module tb_intc_8bit;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] irq_in;
    logic       int_ack;
    logic       interrupt;
    logic [7:0] vector;
    logic       cfg_we;
    logic [1:0] cfg_addr;
    logic [7:0] cfg_wdata;
    logic [7:0] cfg_rdata;

    int vectors = 0;
    int miscompares = 0;

    intc_8bit dut (
        .clk(clk), .reset(reset), .irq_in(irq_in), .int_ack(int_ack),
        .interrupt(interrupt), .vector(vector), .cfg_we(cfg_we),
        .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata), .cfg_rdata(cfg_rdata)
    );

    always #5 clk = ~clk;

    // All stimulus changes at a falling edge; the DUT samples on the next rising edge.
    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic cfg_write(input logic [1:0] a, input logic [7:0] d);
        cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
        @(negedge clk);
        cfg_we = 1'b0; cfg_wdata = 8'h00;
    endtask

    task automatic cfg_read(input logic [1:0] a, output logic [7:0] d);
        cfg_addr = a;
        #1;
        d = cfg_rdata;
    endtask

    task automatic ack_pulse();
        int_ack = 1'b1;
        @(negedge clk);
        int_ack = 1'b0;
    endtask

    task automatic test_reset();
        logic [7:0] r;
        reset = 1'b0; irq_in = '0; int_ack = 1'b0; cfg_we = 1'b0; cfg_addr = 2'd0; cfg_wdata = 8'h00;
        step(2);
        vectors++; if (interrupt !== 1'b0) begin miscompares++; $display("FAIL rst_int: got %b want 0", interrupt); end
        vectors++; if (vector !== 8'h00) begin miscompares++; $display("FAIL rst_vec: got %h want 00", vector); end
        cfg_read(2'd0, r);
        vectors++; if (r !== 8'hFF) begin miscompares++; $display("FAIL rst_mask: got %h want FF", r); end
        cfg_read(2'd1, r);
        vectors++; if (r !== 8'h00) begin miscompares++; $display("FAIL rst_pend: got %h want 00", r); end
        cfg_read(2'd2, r);
        vectors++; if (r !== 8'h00) begin miscompares++; $display("FAIL rst_status: got %h want 00", r); end
        step(1);
        reset = 1'b1;
        step(1);
    endtask

    task automatic test_latency();
        logic [7:0] r;
        cfg_write(2'd0, 8'hFE);
        irq_in = 4'b0001;
        step(1);
        irq_in = 4'b0000;
        step(2);
        vectors++; if (interrupt !== 1'b0) begin miscompares++; $display("FAIL lat_early: got %b want 0", interrupt); end
        cfg_read(2'd1, r);
        vectors++; if (r !== 8'h01) begin miscompares++; $display("FAIL lat_pend: got %h want 01", r); end
        step(1);
        vectors++; if (interrupt !== 1'b1) begin miscompares++; $display("FAIL lat_int: got %b want 1", interrupt); end
        vectors++; if (vector !== 8'hF0) begin miscompares++; $display("FAIL lat_vec: got %h want F0", vector); end
        ack_pulse();
        vectors++; if (interrupt !== 1'b0) begin miscompares++; $display("FAIL lat_ack_int: got %b want 0", interrupt); end
        cfg_read(2'd2, r);
        vectors++; if (r !== 8'h90) begin miscompares++; $display("FAIL lat_status_svc: got %h want 90", r); end
        cfg_read(2'd1, r);
        vectors++; if (r !== 8'h00) begin miscompares++; $display("FAIL lat_pend_clr: got %h want 00", r); end
        cfg_write(2'd3, 8'h00);
        cfg_read(2'd2, r);
        vectors++; if (r !== 8'h00) begin miscompares++; $display("FAIL lat_status_eoi: got %h want 00", r); end
        vectors++; if (vector !== 8'h00) begin miscompares++; $display("FAIL lat_vec_idle: got %h want 00", vector); end
    endtask

    task automatic test_priority();
        logic [7:0] r;
        cfg_write(2'd0, 8'h00);
        irq_in = 4'b1010;
        step(3);
        cfg_read(2'd1, r);
        vectors++; if (r !== 8'h0A) begin miscompares++; $display("FAIL pri_pend: got %h want 0A", r); end
        step(1);
        vectors++; if (interrupt !== 1'b1) begin miscompares++; $display("FAIL pri_int1: got %b want 1", interrupt); end
        vectors++; if (vector !== 8'hF4) begin miscompares++; $display("FAIL pri_vec1: got %h want F4", vector); end
        ack_pulse();
        cfg_read(2'd2, r);
        vectors++; if (r !== 8'h91) begin miscompares++; $display("FAIL pri_status1: got %h want 91", r); end
        cfg_write(2'd3, 8'h00);
        cfg_read(2'd2, r);
        vectors++; if (r !== 8'h01) begin miscompares++; $display("FAIL pri_status_idle: got %h want 01", r); end
        step(1);
        vectors++; if (interrupt !== 1'b1) begin miscompares++; $display("FAIL pri_int2: got %b want 1", interrupt); end
        vectors++; if (vector !== 8'hFC) begin miscompares++; $display("FAIL pri_vec2: got %h want FC", vector); end
        ack_pulse();
        cfg_write(2'd3, 8'h00);
        irq_in = 4'b0000;
        step(3);
        cfg_read(2'd2, r);
        vectors++; if (r !== 8'h03) begin miscompares++; $display("FAIL pri_status_end: got %h want 03", r); end
    endtask

    task automatic test_masked();
        logic [7:0] r;
        cfg_write(2'd0, 8'h04);
        irq_in = 4'b0100;
        step(1);
        irq_in = 4'b0000;
        step(4);
        cfg_read(2'd1, r);
        vectors++; if (r !== 8'h04) begin miscompares++; $display("FAIL msk_pend: got %h want 04", r); end
        vectors++; if (interrupt !== 1'b0) begin miscompares++; $display("FAIL msk_int_held: got %b want 0", interrupt); end
        cfg_write(2'd0, 8'h00);
        step(1);
        vectors++; if (interrupt !== 1'b1) begin miscompares++; $display("FAIL msk_unmask_int: got %b want 1", interrupt); end
        vectors++; if (vector !== 8'hF8) begin miscompares++; $display("FAIL msk_vec: got %h want F8", vector); end
        ack_pulse();
        cfg_write(2'd3, 8'h00);
        cfg_read(2'd2, r);
        vectors++; if (r !== 8'h02) begin miscompares++; $display("FAIL msk_status_end: got %h want 02", r); end
    endtask

    task automatic test_commit();
        logic [7:0] r;
        irq_in = 4'b0010;
        step(1);
        irq_in = 4'b0000;
        step(3);
        vectors++; if (interrupt !== 1'b1) begin miscompares++; $display("FAIL cmt_int: got %b want 1", interrupt); end
        cfg_write(2'd0, 8'hFF);
        cfg_write(2'd1, 8'h02);
        step(2);
        vectors++; if (interrupt !== 1'b1) begin miscompares++; $display("FAIL cmt_int_masked: got %b want 1", interrupt); end
        vectors++; if (vector !== 8'hF4) begin miscompares++; $display("FAIL cmt_vec: got %h want F4", vector); end
        cfg_read(2'd1, r);
        vectors++; if (r !== 8'h00) begin miscompares++; $display("FAIL cmt_pend_w1c: got %h want 00", r); end
        // Re-edge timed so pending is set on the same edge that samples int_ack.
        irq_in = 4'b0010;
        step(1);
        irq_in = 4'b0000;
        step(1);
        ack_pulse();
        vectors++; if (interrupt !== 1'b0) begin miscompares++; $display("FAIL cmt_ack_int: got %b want 0", interrupt); end
        cfg_read(2'd1, r);
        vectors++; if (r !== 8'h02) begin miscompares++; $display("FAIL cmt_pend_setwins: got %h want 02", r); end
        cfg_read(2'd2, r);
        vectors++; if (r !== 8'h91) begin miscompares++; $display("FAIL cmt_status: got %h want 91", r); end
        cfg_write(2'd3, 8'h00);
        ack_pulse();
        cfg_write(2'd3, 8'h00);
        step(1);
        vectors++; if (interrupt !== 1'b0) begin miscompares++; $display("FAIL cmt_idle_int: got %b want 0", interrupt); end
        cfg_read(2'd2, r);
        vectors++; if (r !== 8'h01) begin miscompares++; $display("FAIL cmt_idle_ignores: got %h want 01", r); end
        cfg_write(2'd1, 8'h02);
        cfg_read(2'd1, r);
        vectors++; if (r !== 8'h00) begin miscompares++; $display("FAIL cmt_pend_final: got %h want 00", r); end
    endtask

    task automatic test_async_reset();
        logic [7:0] r;
        cfg_write(2'd0, 8'h00);
        irq_in = 4'b0001;
        step(1);
        irq_in = 4'b0000;
        step(3);
        ack_pulse();
        irq_in = 4'b1000;
        step(1);
        irq_in = 4'b0000;
        step(2);
        cfg_read(2'd1, r);
        vectors++; if (r !== 8'h08) begin miscompares++; $display("FAIL ar_pend_pre: got %h want 08", r); end
        #1;
        reset = 1'b0;
        #1;
        vectors++; if (interrupt !== 1'b0) begin miscompares++; $display("FAIL ar_int: got %b want 0", interrupt); end
        vectors++; if (vector !== 8'h00) begin miscompares++; $display("FAIL ar_vec: got %h want 00", vector); end
        cfg_read(2'd0, r);
        vectors++; if (r !== 8'hFF) begin miscompares++; $display("FAIL ar_mask: got %h want FF", r); end
        cfg_read(2'd1, r);
        vectors++; if (r !== 8'h00) begin miscompares++; $display("FAIL ar_pend: got %h want 00", r); end
        step(1);
        reset = 1'b1;
        step(4);
        vectors++; if (interrupt !== 1'b0) begin miscompares++; $display("FAIL ar_no_resume: got %b want 0", interrupt); end
    endtask

    task automatic test_nested();
        logic [7:0] r;
        cfg_write(2'd0, 8'h00);
        irq_in = 4'b0100;
        step(1);
        irq_in = 4'b0000;
        step(3);
        ack_pulse();
        cfg_read(2'd2, r);
        vectors++; if (r !== 8'h92) begin miscompares++; $display("FAIL nst_status_svc2: got %h want 92", r); end
        irq_in = 4'b0001;
        step(1);
        irq_in = 4'b0000;
        step(3);
`ifdef INTC_NESTED_EN
        vectors++; if (interrupt !== 1'b1) begin miscompares++; $display("FAIL nst_preempt_int: got %b want 1", interrupt); end
        vectors++; if (vector !== 8'hF0) begin miscompares++; $display("FAIL nst_preempt_vec: got %h want F0", vector); end
        ack_pulse();
        cfg_read(2'd2, r);
        vectors++; if (r !== 8'h90) begin miscompares++; $display("FAIL nst_status_svc0: got %h want 90", r); end
        cfg_write(2'd3, 8'h00);
        cfg_read(2'd2, r);
        vectors++; if (r !== 8'h92) begin miscompares++; $display("FAIL nst_status_back2: got %h want 92", r); end
        vectors++; if (vector !== 8'hF8) begin miscompares++; $display("FAIL nst_vec_back2: got %h want F8", vector); end
        cfg_write(2'd3, 8'h00);
        cfg_read(2'd2, r);
        vectors++; if (r !== 8'h02) begin miscompares++; $display("FAIL nst_status_idle: got %h want 02", r); end
`else
        vectors++; if (interrupt !== 1'b0) begin miscompares++; $display("FAIL nst_no_preempt: got %b want 0", interrupt); end
        cfg_read(2'd2, r);
        vectors++; if (r !== 8'h92) begin miscompares++; $display("FAIL nst_status_hold: got %h want 92", r); end
        cfg_read(2'd1, r);
        vectors++; if (r !== 8'h01) begin miscompares++; $display("FAIL nst_pend_wait: got %h want 01", r); end
        cfg_write(2'd3, 8'h00);
        cfg_read(2'd2, r);
        vectors++; if (r !== 8'h02) begin miscompares++; $display("FAIL nst_status_idle: got %h want 02", r); end
        step(1);
        vectors++; if (interrupt !== 1'b1) begin miscompares++; $display("FAIL nst_late_int: got %b want 1", interrupt); end
        vectors++; if (vector !== 8'hF0) begin miscompares++; $display("FAIL nst_late_vec: got %h want F0", vector); end
        ack_pulse();
        cfg_write(2'd3, 8'h00);
        cfg_read(2'd2, r);
        vectors++; if (r !== 8'h00) begin miscompares++; $display("FAIL nst_status_end: got %h want 00", r); end
`endif
    endtask

    initial begin
        test_reset();
        test_latency();
        test_priority();
        test_masked();
        test_commit();
        test_async_reset();
        test_nested();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, %0d vectors applied", vectors);
        $fatal(1, "timeout");
    end

endmodule
